seq_match_ctrl: RTL and testbench

Controller for a runtime-programmable serial sequence detector. It accepts a pattern configuration through a valid/ready handshake and arms detection on a start command. It counts pattern matches on a qualified bit stream, with optional overlap, and stops with a sticky done flag once a target match count is reached. It generalises the fixed-pattern detectors in the sequence_detector family to a configurable pattern under one scheduler.

---
 rtl/seq_ctrl_pkg.sv | 28 ++
 rtl/seq_match_ctrl_if.sv | 39 +++
 rtl/seq_window_match.sv | 57 +++++
 rtl/seq_match_ctrl.sv | 135 +++++++++++++
 tb/tb_seq_match_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the programmable sequence-match controller.
//   state_t  : controller states (IDLE, RUN, DONE)
//   cfg_t    : pattern configuration at the default widths
//   len_legal: pattern-length range check shared by the controller
package seq_ctrl_pkg;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_LEN_W = $clog2(DEF_PAT_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_PAT_W-1:0] pattern;
        logic [DEF_LEN_W-1:0] len;
        logic                 overlap;
        logic [DEF_CNT_W-1:0] target;
    } cfg_t;

    function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
        return (len >= 1) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Bundle of configuration, command, stream and status signals of seq_match_ctrl.
//   master: drives cfg_*, start, abort, in_*, done_ack; observes status
//   slave : the controller side
interface seq_match_ctrl_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_err;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             busy;
    logic             done;
    logic             done_ack;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, in_valid, in_bit, done_ack,
        input  cfg_ready, cfg_err, match, match_count, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, in_valid, in_bit, done_ack,
        output cfg_ready, cfg_err, match, match_count, busy, done
    );

endinterface

// File: rtl/seq_window_match.sv
// Bit history window with fill tracking and length-masked pattern compare.
//   shift_en : accept bit_in this cycle
//   clear    : empty the window (overrides shift)
//   pattern  : reference pattern, bit [len-1] oldest
//   len      : active pattern length
//   hit      : combinational; the window including bit_in matches this cycle
module seq_window_match #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [PAT_W-1:0] history_q, history_d, history_next;
    logic [LEN_W-1:0] fill_q, fill_d, fill_next;
    logic [PAT_W-1:0] mask;

    always_comb begin
        history_next = (history_q << 1) | PAT_W'(bit_in);
        fill_next    = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;

        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end

        hit = shift_en && (fill_next >= len) &&
              (((history_next ^ pattern) & mask) == '0);

        history_d = history_q;
        fill_d    = fill_q;
        if (clear) begin
            history_d = '0;
            fill_d    = '0;
        end else if (shift_en) begin
            history_d = history_next;
            fill_d    = fill_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial sequence-match controller.
//   clk, reset : clock, synchronous active-high reset
//   bus        : cfg handshake (cfg_valid/ready, pattern, len, overlap, target, cfg_err),
//                commands (start, abort, done_ack), stream (in_valid, in_bit),
//                status (match pulse, match_count, busy, done)
module seq_match_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    seq_match_ctrl_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

    // Same shape as the package cfg_t, sized to this instance.
    typedef struct packed {
        logic [PAT_W-1:0] pattern;
        logic [LEN_W-1:0] len;
        logic             overlap;
        logic [CNT_W-1:0] target;
    } cfg_reg_t;

    state_t           state_q, state_d;
    cfg_reg_t         cfg_q, cfg_d;
    logic             loaded_q, loaded_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             shift_en, win_clear, hit;

    seq_window_match #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_window (
        .clk     (clk),
        .reset   (reset),
        .shift_en(shift_en),
        .clear   (win_clear),
        .bit_in  (bus.in_bit),
        .pattern (cfg_q.pattern),
        .len     (cfg_q.len),
        .hit     (hit)
    );

    assign bus.cfg_ready   = (state_q == IDLE) && !reset;
    assign bus.cfg_err     = err_q;
    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        loaded_d  = loaded_q;
        match_d   = 1'b0;
        count_d   = count_q;
        err_d     = 1'b0;
        shift_en  = 1'b0;
        win_clear = 1'b0;
        count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                // A configuration offer takes priority over start.
                if (bus.cfg_valid) begin
                    if (len_legal(32'(bus.cfg_len), PAT_W)) begin
                        cfg_d.pattern = bus.cfg_pattern;
                        cfg_d.len     = bus.cfg_len;
                        cfg_d.overlap = bus.cfg_overlap;
                        cfg_d.target  = bus.cfg_target;
                        loaded_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.start && loaded_q) begin
                    state_d   = RUN;
                    win_clear = 1'b1;
                    count_d   = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    shift_en = 1'b1;
                    if (hit) begin
                        match_d = 1'b1;
                        count_d = count_inc;
                        // Without overlap the window restarts empty after a hit.
                        win_clear = !cfg_q.overlap;
                        if ((cfg_q.target != '0) && (count_inc == cfg_q.target)) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (bus.done_ack || bus.abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            loaded_q <= 1'b0;
            match_q  <= 1'b0;
            count_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            loaded_q <= loaded_d;
            match_q  <= match_d;
            count_q  <= count_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench for seq_match_ctrl: directed scenarios followed by random
// stimulus, all compared every cycle against a queue-based reference model.
module tb_seq_match_ctrl;

    localparam int unsigned PW = 8;
    localparam int unsigned CW = 8;

    logic clk;
    logic reset;

    seq_match_ctrl_if #(.PAT_W(PW), .CNT_W(CW)) bus ();

    seq_match_ctrl #(.PAT_W(PW), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: modes 0=idle 1=running 2=finished
    int       m_mode;
    bit       m_loaded;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ov;
    int       m_tgt;
    bit       m_match;
    int       m_count;
    bit       m_err;
    bit       hist[$];   // bits seen and still usable, oldest first

    function automatic bit tail_matches();
        int n = hist.size();
        if (n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (hist[n-1-k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        m_match = 1'b0;
        m_err   = 1'b0;
        if (reset) begin
            m_mode = 0; m_loaded = 0; m_count = 0;
            m_pat = '0; m_len = 0; m_ov = 0; m_tgt = 0;
            hist.delete();
            return;
        end
        case (m_mode)
            0: begin
                if (bus.cfg_valid) begin
                    if (bus.cfg_len >= 1 && bus.cfg_len <= PW) begin
                        m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
                        m_ov = bus.cfg_overlap; m_tgt = int'(bus.cfg_target);
                        m_loaded = 1;
                    end else begin
                        m_err = 1;
                    end
                end else if (bus.start && m_loaded) begin
                    m_mode = 1; m_count = 0; hist.delete();
                end
            end
            1: begin
                if (bus.abort) begin
                    m_mode = 0;
                end else if (bus.in_valid) begin
                    hist.push_back(bus.in_bit);
                    if (hist.size() > PW) void'(hist.pop_front());
                    if (tail_matches()) begin
                        m_match = 1;
                        if (m_count < 255) m_count++;
                        if (!m_ov) hist.delete();
                        if (m_tgt != 0 && m_count == m_tgt) m_mode = 2;
                    end
                end
            end
            default: begin
                if (bus.done_ack || bus.abort) m_mode = 0;
            end
        endcase
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("match", 32'(bus.match), 32'(m_match));
        chk("match_count", 32'(bus.match_count), 32'(m_count));
        chk("busy", 32'(bus.busy), 32'(m_mode == 1));
        chk("done", 32'(bus.done), 32'(m_mode == 2));
        chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_mode == 0 && !reset));
    endtask

    task automatic idle_inputs();
        bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.cfg_overlap = 0; bus.cfg_target = '0; bus.start = 0;
        bus.abort = 0; bus.in_valid = 0; bus.in_bit = 0; bus.done_ack = 0;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                          input logic ov, input logic [7:0] tgt);
        bus.cfg_valid = 1; bus.cfg_pattern = pat; bus.cfg_len = len;
        bus.cfg_overlap = ov; bus.cfg_target = tgt;
        cyc();
        bus.cfg_valid = 0;
    endtask

    task automatic do_start();
        bus.start = 1; cyc(); bus.start = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.in_valid = 1; bus.in_bit = b; cyc(); bus.in_valid = 0;
    endtask

    task automatic send_stream(input logic [6:0] s);
        for (int i = 6; i >= 0; i--) send_bit(s[i]);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        cyc(); cyc();
        chk("reset_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        reset = 0;
        cyc();
        chk("cfg_ready_after_reset", 32'(bus.cfg_ready), 32'd1);

        // Illegal lengths and start before any legal configuration
        do_cfg(8'h0B, 4'd0, 1, 8'd0);
        chk("err_len0", 32'(bus.cfg_err), 32'd1);
        do_start();
        chk("start_unloaded_busy", 32'(bus.busy), 32'd0);
        do_cfg(8'h0B, 4'd9, 1, 8'd0);
        chk("err_len9", 32'(bus.cfg_err), 32'd1);
        cyc();

        // Overlapping
        do_cfg(8'b0000_1011, 4'd4, 1, 8'd0);
        do_start();
        send_stream(7'b1011011);
        chk("ovl_count", 32'(bus.match_count), 32'd2);
        chk("ovl_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1; cyc(); bus.abort = 0;

        // Non-overlapping
        do_cfg(8'b0000_1011, 4'd4, 0, 8'd0);
        do_start();
        send_stream(7'b1011011);
        chk("novl_count", 32'(bus.match_count), 32'd1);
        bus.abort = 1; cyc(); bus.abort = 0;

        // Target stop and ack
        do_cfg(8'b0000_1011, 4'd4, 1, 8'd2);
        do_start();
        send_stream(7'b1011011);
        chk("tgt_done", 32'(bus.done), 32'd1);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        chk("tgt_count_held", 32'(bus.match_count), 32'd2);
        bus.start = 1; cyc(); bus.start = 0;
        chk("start_in_done", 32'(bus.done), 32'd1);
        bus.done_ack = 1; cyc(); bus.done_ack = 0;
        chk("ack_done", 32'(bus.done), 32'd0);
        chk("ack_count", 32'(bus.match_count), 32'd2);

        // Abort on completing bit
        do_cfg(8'b0000_1011, 4'd4, 1, 8'd0);
        do_start();
        send_bit(1); send_bit(0); send_bit(1);
        bus.in_valid = 1; bus.in_bit = 1; bus.abort = 1;
        cyc();
        idle_inputs();
        chk("abort_match", 32'(bus.match), 32'd0);
        chk("abort_count", 32'(bus.match_count), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);

        // Gaps between valid bits
        do_start();
        send_bit(1); cyc(); send_bit(0); cyc(); cyc(); send_bit(1); cyc(); send_bit(1);
        chk("gap_match", 32'(bus.match), 32'd1);
        cyc();
        chk("gap_count", 32'(bus.match_count), 32'd1);

        // Reset mid-run loses configuration
        reset = 1; cyc(); reset = 0; cyc();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        do_start();
        chk("rst_start_ignored", 32'(bus.busy), 32'd0);

        // Config wins over simultaneous start
        bus.start = 1;
        do_cfg(8'b0000_0101, 4'd3, 1, 8'd0);
        bus.start = 0;
        chk("cfg_start_idle", 32'(bus.busy), 32'd0);
        do_start();
        chk("start_after_cfg", 32'(bus.busy), 32'd1);
        send_stream(7'b0101010);
        chk("p101_count", 32'(bus.match_count), 32'd2);

        // Random phase
        for (int n = 0; n < 4000; n++) begin
            idle_inputs();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.cfg_valid   = 1;
                bus.cfg_pattern = 8'($urandom);
                bus.cfg_len     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                                               : 4'($urandom_range(1, 4));
                bus.cfg_overlap = 1'($urandom);
                bus.cfg_target  = 8'($urandom_range(0, 4));
            end
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.abort    = ($urandom_range(0, 59) == 0);
            bus.done_ack = ($urandom_range(0, 5) == 0);
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.in_bit   = 1'($urandom);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
